rv32mc: RTL and testbench

RV32MC -- requirements
Module: rv32mc

---
 rtl/rv32mc.sv | 253 +++++++++++++++++++++++++
 tb/tb_rv32mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32mc.sv
// Multi-cycle RV32I/RV32E core: FETCH -> DECODE -> EXEC -> (MEM) -> WB, one instruction in flight.
// Halts permanently on illegal/system opcodes, out-of-range registers or misaligned jump targets.
module rv32mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imemaddr,
  output logic        imemreq,
  input  logic        imemack,
  input  logic [31:0] imemdataout,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemdatain,
  output logic [2:0]  dmemop,
  output logic        dmemwe,
  output logic        dmemreq,
  input  logic        dmemack,
  input  logic [31:0] dmemdataout,
  output logic        halt,
  output logic [31:0] dbgdata
);

  localparam int unsigned RIDX = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_t;

  state_t      state;
  logic [31:0] pc, ir, rs1_val, rs2_val, result, next_pc;
  logic [31:0] regs [NREGS];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, op_b, alu, exec_result, target;
  logic        legal, uses_rs1, uses_rs2, writes_rd, bad_reg, taken, redirect, is_mem;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imemaddr = pc;
  assign dbgdata  = pc;

  always_comb begin
    imm       = '0;
    legal     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OpLui, OpAuipc: begin
        imm = {ir[31:12], 12'b0};
        legal = 1'b1;
        writes_rd = 1'b1;
      end
      OpJal: begin
        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        legal = 1'b1;
        writes_rd = 1'b1;
      end
      OpJalr: begin
        imm = {{20{ir[31]}}, ir[31:20]};
        legal = (funct3 == 3'd0);
        uses_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      OpBranch: begin
        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        legal = (funct3[2:1] != 2'b01);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpLoad: begin
        imm = {{20{ir[31]}}, ir[31:20]};
        legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        uses_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      OpStore: begin
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        legal = funct3 inside {3'd0, 3'd1, 3'd2};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpImm: begin
        imm = {{20{ir[31]}}, ir[31:20]};
        if (funct3 == 3'd1) legal = (funct7 == 7'h00);
        else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else legal = 1'b1;
        uses_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      OpReg: begin
        legal = (funct7 == 7'h00) || ((funct7 == 7'h20) && (funct3 == 3'd0 || funct3 == 3'd5));
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        writes_rd = 1'b1;
      end
      OpFence: legal = 1'b1;
      default: legal = 1'b0;  // SYSTEM (ECALL/EBREAK/CSR) and unknown opcodes
    endcase
  end

  // Only fields the instruction actually uses are range-checked on RV32E.
  assign bad_reg = (NREGS == 16) &&
                   ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (writes_rd && rd[4]));

  assign op_b   = (opcode == OpReg) ? rs2_val : imm;
  assign is_mem = (opcode == OpLoad) || (opcode == OpStore);

  always_comb begin
    alu = '0;
    case (funct3)
      3'd0: alu = ((opcode == OpReg) && funct7[5]) ? rs1_val - op_b : rs1_val + op_b;
      3'd1: alu = rs1_val << op_b[4:0];
      3'd2: alu = {31'b0, $signed(rs1_val) < $signed(op_b)};
      3'd3: alu = {31'b0, rs1_val < op_b};
      3'd4: alu = rs1_val ^ op_b;
      3'd5: alu = funct7[5] ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'd6: alu = rs1_val | op_b;
      default: alu = rs1_val & op_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'd0: taken = (rs1_val == rs2_val);
      3'd1: taken = (rs1_val != rs2_val);
      3'd4: taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: taken = (rs1_val < rs2_val);
      3'd7: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    exec_result = alu;
    target      = pc + 32'd4;
    redirect    = 1'b0;
    case (opcode)
      OpLui:   exec_result = imm;
      OpAuipc: exec_result = pc + imm;
      OpJal: begin
        exec_result = pc + 32'd4;
        target = pc + imm;
        redirect = 1'b1;
      end
      OpJalr: begin
        exec_result = pc + 32'd4;
        target = (rs1_val + imm) & ~32'd1;
        redirect = 1'b1;
      end
      OpBranch: begin
        if (taken) target = pc + imm;
        redirect = taken;
      end
      OpLoad, OpStore: exec_result = rs1_val + imm;
      default: exec_result = alu;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= StFetch;
      pc      <= RESET_PC;
      imemreq <= 1'b0;
      dmemreq <= 1'b0;
      dmemwe  <= 1'b0;
      halt    <= 1'b0;
    end else begin
      unique case (state)
        StFetch: begin
          if (!imemreq) begin
            imemreq <= 1'b1;
          end else if (imemack) begin
            ir      <= imemdataout;
            imemreq <= 1'b0;
            state   <= StDecode;
          end
        end
        StDecode: begin
          if (!legal || bad_reg) begin
            halt  <= 1'b1;
            state <= StHalt;
          end else begin
            rs1_val <= (rs1 == 5'd0) ? 32'd0 : regs[rs1[RIDX-1:0]];
            rs2_val <= (rs2 == 5'd0) ? 32'd0 : regs[rs2[RIDX-1:0]];
            state   <= StExec;
          end
        end
        StExec: begin
          if (redirect && (target[1:0] != 2'b00)) begin
            halt  <= 1'b1;
            state <= StHalt;
          end else begin
            result  <= exec_result;
            next_pc <= target;
            if (is_mem) begin
              dmemaddr   <= exec_result;
              dmemdatain <= rs2_val;
              dmemop     <= funct3;
              dmemwe     <= (opcode == OpStore);
              dmemreq    <= 1'b1;
              state      <= StMem;
            end else begin
              state <= StWb;
            end
          end
        end
        StMem: begin
          if (dmemack) begin
            if (!dmemwe) result <= dmemdataout;
            dmemreq <= 1'b0;
            state   <= StWb;
          end
        end
        StWb: begin
          pc      <= next_pc;
          imemreq <= 1'b1;
          state   <= StFetch;
        end
        default: begin
          halt  <= 1'b1;
          state <= StHalt;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && (state == StWb) && writes_rd && (rd != 5'd0)) begin
      regs[rd[RIDX-1:0]] <= result;
    end
  end

endmodule

// File: tb/tb_rv32mc.sv
// Directed bench for rv32mc: ALU, load/store with wait states, branches/jumps, halts, RV32E and
// reset behaviour, observed through the memory ports.
module tb_rv32mc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imemaddr, imemdataout, dmemaddr, dmemdatain, dmemdataout, dbgdata;
  logic        imemreq, imemack, dmemwe, dmemreq, dmemack, halt;
  logic [2:0]  dmemop;

  logic        e_reset = 1'b1;
  logic [31:0] e_imemaddr, e_imemdata, e_dmemaddr, e_dmemdatain, e_dbgdata;
  logic        e_imemreq, e_dmemwe, e_dmemreq, e_halt;
  logic [2:0]  e_dmemop;
  logic        e_dmemack = 1'b0;
  logic [31:0] e_dmemdataout = 32'd0;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  logic        iack_en = 1'b0;
  logic        dack_force = 1'b0;
  int          ddelay = 0;
  int          dcnt = 0;
  int          cyc = 0;
  int          dreq_cycles = 0;
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  logic [31:0] f_pc [$];
  int          f_cyc [$];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rv32mc #(.RESET_PC(32'h0000_0000), .NREGS(32)) dut (
    .clock(clock), .reset(reset),
    .imemaddr(imemaddr), .imemreq(imemreq), .imemack(imemack), .imemdataout(imemdataout),
    .dmemaddr(dmemaddr), .dmemdatain(dmemdatain), .dmemop(dmemop), .dmemwe(dmemwe),
    .dmemreq(dmemreq), .dmemack(dmemack), .dmemdataout(dmemdataout),
    .halt(halt), .dbgdata(dbgdata)
  );

  rv32mc #(.RESET_PC(32'h0000_0000), .NREGS(16)) dut16 (
    .clock(clock), .reset(e_reset),
    .imemaddr(e_imemaddr), .imemreq(e_imemreq), .imemack(e_imemreq), .imemdataout(e_imemdata),
    .dmemaddr(e_dmemaddr), .dmemdatain(e_dmemdatain), .dmemop(e_dmemop), .dmemwe(e_dmemwe),
    .dmemreq(e_dmemreq), .dmemack(e_dmemack), .dmemdataout(e_dmemdataout),
    .halt(e_halt), .dbgdata(e_dbgdata)
  );

  assign imemack     = imemreq && iack_en;
  assign imemdataout = imem[imemaddr[9:2]];
  assign dmemack     = (dmemreq && (dcnt >= ddelay)) || dack_force;
  assign dmemdataout = dmem[dmemaddr[7:2]];

  always @(posedge clock) begin
    cyc  <= cyc + 1;
    dcnt <= (dmemreq && !dmemack) ? dcnt + 1 : 0;
    if (dmemreq) dreq_cycles <= dreq_cycles + 1;
    if (dmemreq && dmemack && dmemwe) begin
      dmem[dmemaddr[7:2]] <= dmemdatain;
      st_addr.push_back(dmemaddr);
      st_data.push_back(dmemdatain);
    end
    if (imemreq && imemack) begin
      f_pc.push_back(imemaddr);
      f_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0073;  // ECALL stops runaway programs
  endtask

  task automatic clear_logs();
    st_addr.delete();
    st_data.delete();
    f_pc.delete();
    f_cyc.delete();
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!halt && n < budget) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int n;
    int dreq_base;
    int st_n;
    logic [31:0] exp_pc [7];
    logic [31:0] exp_a [7];
    logic [31:0] exp_d [7];

    // Program A: ADDI, ADDI, SW, LW, SW, ECALL with three data wait states
    clear_imem();
    clear_logs();
    imem[0] = 32'h0050_0093;  // addi x1,x0,5
    imem[1] = 32'hFF90_8113;  // addi x2,x1,-7
    imem[2] = 32'h0020_2423;  // sw   x2,8(x0)
    imem[3] = 32'h0080_2183;  // lw   x3,8(x0)
    imem[4] = 32'h0030_2623;  // sw   x3,12(x0)
    ddelay = 3;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst imemreq", {31'b0, imemreq}, 32'd0);
    check("rst dmemreq", {31'b0, dmemreq}, 32'd0);
    check("rst halt", {31'b0, halt}, 32'd0);
    check("rst imemaddr", imemaddr, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("fetch hold req", {31'b0, imemreq}, 32'd1);
    check("fetch hold addr", imemaddr, 32'h0);
    iack_en = 1'b1;
    n = 0;
    while (!dmemreq && n < 40) begin
      @(negedge clock);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      check("sw req", {31'b0, dmemreq}, 32'd1);
      check("sw addr", dmemaddr, 32'h8);
      check("sw we", {31'b0, dmemwe}, 32'd1);
      check("sw data", dmemdatain, 32'hFFFF_FFFE);
      check("sw op", {29'b0, dmemop}, 32'd2);
      check("sw no imemreq", {31'b0, imemreq}, 32'd0);
      @(negedge clock);
    end
    n = 0;
    while (!dmemreq && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("lw addr", dmemaddr, 32'h8);
    check("lw we", {31'b0, dmemwe}, 32'd0);
    check("lw op", {29'b0, dmemop}, 32'd2);
    wait_halt(200);
    check("A halt", {31'b0, halt}, 32'd1);
    check("A halt pc", dbgdata, 32'h14);
    check("A stores", st_addr.size(), 32'd2);
    check("A x2", st_data[0], 32'hFFFF_FFFE);
    check("A x3 addr", st_addr[1], 32'hC);
    check("A x3", st_data[1], 32'hFFFF_FFFE);
    check("A fetches", f_cyc.size(), 32'd6);
    check("A addi cycles", 32'(f_cyc[1] - f_cyc[0]), 32'd4);
    check("A addi2 cycles", 32'(f_cyc[2] - f_cyc[1]), 32'd4);
    check("A sw cycles", 32'(f_cyc[3] - f_cyc[2]), 32'd8);
    check("A lw cycles", 32'(f_cyc[4] - f_cyc[3]), 32'd8);
    repeat (5) @(negedge clock);
    check("A halt imemreq", {31'b0, imemreq}, 32'd0);
    check("A halt dmemreq", {31'b0, dmemreq}, 32'd0);
    check("A halt pc frozen", imemaddr, 32'h14);

    // Program B: jumps and branches, ending in a misaligned JAL
    clear_imem();
    clear_logs();
    imem[0]  = 32'h1000_0293;  // addi x5,x0,0x100
    imem[1]  = 32'h00C0_006F;  // jal  x0,+12 -> 0x10
    imem[2]  = 32'h0400_1063;  // bne  x0,x0,+64 (not taken)
    imem[3]  = 32'h0012_80E7;  // jalr x1,1(x5) -> 0x100, x1=0x10
    imem[4]  = 32'hFE00_0CE3;  // beq  x0,x0,-8 -> 0x08
    imem[64] = 32'h0010_2023;  // sw   x1,0(x0)
    imem[65] = 32'h0020_00EF;  // jal  x1,+2 -> misaligned halt
    ddelay = 0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_halt(300);
    exp_pc = '{32'h0, 32'h4, 32'h10, 32'h8, 32'hC, 32'h100, 32'h104};
    check("B fetches", f_pc.size(), 32'd7);
    for (int i = 0; i < 7; i++) check($sformatf("B fetch%0d", i), f_pc[i], exp_pc[i]);
    check("B jalr link", st_data[0], 32'h10);
    check("B halt", {31'b0, halt}, 32'd1);
    check("B halt pc", dbgdata, 32'h104);

    // Program C: registers survive reset; ALU ops and x0 discard
    clear_imem();
    clear_logs();
    imem[0]  = 32'h0010_2023;  // sw    x1,0(x0)
    imem[1]  = 32'h8000_0337;  // lui   x6,0x80000
    imem[2]  = 32'h4043_5393;  // srai  x7,x6,4
    imem[3]  = 32'h0070_2223;  // sw    x7,4(x0)
    imem[4]  = 32'h0013_2433;  // slt   x8,x6,x1
    imem[5]  = 32'h0013_34B3;  // sltu  x9,x6,x1
    imem[6]  = 32'h0080_2423;  // sw    x8,8(x0)
    imem[7]  = 32'h0090_2623;  // sw    x9,12(x0)
    imem[8]  = 32'h0000_1597;  // auipc x11,1
    imem[9]  = 32'h00B0_2823;  // sw    x11,16(x0)
    imem[10] = 32'h4010_0633;  // sub   x12,x0,x1
    imem[11] = 32'h00C0_2A23;  // sw    x12,20(x0)
    imem[12] = 32'h0050_0013;  // addi  x0,x0,5
    imem[13] = 32'h0000_2C23;  // sw    x0,24(x0)
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_halt(400);
    exp_a = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24};
    exp_d = '{32'h10, 32'hF800_0000, 32'd1, 32'd0, 32'h1020, 32'hFFFF_FFF0, 32'd0};
    check("C stores", st_addr.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("C addr%0d", i), st_addr[i], exp_a[i]);
      check($sformatf("C data%0d", i), st_data[i], exp_d[i]);
    end

    // Reset in the middle of a stalled store
    clear_imem();
    imem[0] = 32'h0000_2823;  // sw x0,16(x0)
    ddelay = 20;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (!dmemreq && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("D in mem", {31'b0, dmemreq}, 32'd1);
    reset = 1'b1;
    imem[0] = 32'h0000_0073;
    @(negedge clock);
    check("D dmemreq", {31'b0, dmemreq}, 32'd0);
    check("D imemreq", {31'b0, imemreq}, 32'd0);
    check("D imemaddr", imemaddr, 32'h0);
    dreq_base = dreq_cycles;
    st_n = st_addr.size();
    dack_force = 1'b1;
    reset = 1'b0;
    repeat (6) @(negedge clock);
    dack_force = 1'b0;
    wait_halt(50);
    check("D no reissue", 32'(dreq_cycles - dreq_base), 32'd0);
    check("D no store", 32'(st_addr.size() - st_n), 32'd0);
    check("D halt pc", dbgdata, 32'h0);

    // RV32E: legal ADD x3 keeps running, ADD x17 halts after decode
    e_imemdata = 32'h0020_81B3;
    e_reset = 1'b1;
    @(negedge clock);
    e_reset = 1'b0;
    repeat (20) @(negedge clock);
    check("E legal no halt", {31'b0, e_halt}, 32'd0);
    e_imemdata = 32'h0020_88B3;
    e_reset = 1'b1;
    @(negedge clock);
    e_reset = 1'b0;
    n = 0;
    while (!e_imemreq && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("E fetch", {31'b0, e_imemreq}, 32'd1);
    @(negedge clock);
    check("E decode no halt", {31'b0, e_halt}, 32'd0);
    @(negedge clock);
    check("E halt", {31'b0, e_halt}, 32'd1);
    repeat (10) @(negedge clock);
    check("E halt imemreq", {31'b0, e_imemreq}, 32'd0);
    check("E halt dmemreq", {31'b0, e_dmemreq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
